yacht_turn_sequencer: RTL
=========================

# yacht_turn_sequencer

- Turn-level controller that sequences the dice-roll datapath for one player across a full game.
- Converts raw roll/score button levels into `roll_en` pulse bursts (shuffle animation) and `clear_dice` pulses, and masks the DIP hold switches.
- Enforces the per-turn roll budget, hands each finished turn to the scoring logic through a req/ack handshake, and counts rounds to game over.
- Sits between the board inputs and the dice manager / scoring block.

## Interface
Parameters:
- `MAX_ROLLS`, 3: rolls allowed per turn (1..3).
- `ANIM_STEPS`, 8: `roll_en` pulses per roll (1..255).
- `ANIM_PERIOD`, 16: cycles between consecutive `roll_en` pulses (2..65535).
- `NUM_ROUNDS`, 12: turns per game (1..15).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `roll_btn` input 1: roll request level, already synchronized and debounced.
- `score_btn` input 1: end-turn/score request level, already synchronized and debounced.
- `hold_sw` input 5: raw hold switches, bit i = die i+1.
- `score_ack` input 1: scoring block has consumed the current dice.
- `roll_en` output 1: one-cycle roll strobe to the dice manager.
- `clear_dice` output 1: one-cycle strobe that zeroes all dice.
- `hold_mask` output 5: hold vector presented to the dice manager.
- `rolls_left` output 2: rolls remaining in the current turn.
- `round_num` output 4: current round, 1-based.
- `score_req` output 1: dice are final and awaiting scoring.
- `game_over` output 1: all rounds scored.

## Operation
- Rising-edge detect on `roll_btn` and `score_btn` using one previous-value register each. That register resets to 1, so a button held through reset does not fire.
- States: CLEAR, IDLE, ROLLING, SETTLED, SCORING, NEXT, DONE.
- **CLEAR** (entered from reset):
  - `clear_dice`=1 for one cycle; `rolls_left`=`MAX_ROLLS`; go to IDLE.
- **IDLE**:
  - Roll edge: capture `hold_mask`=0 (holds are ignored on a turn's first roll), decrement `rolls_left`, go to ROLLING.
  - Score edge: ignored.
- **ROLLING**:
  - Step counter and period counter drive `ANIM_STEPS` `roll_en` pulses, spaced `ANIM_PERIOD` cycles apart.
  - `hold_mask` stays frozen for the whole roll, even if `hold_sw` changes.
  - Button edges are ignored.
  - The cycle after the last pulse, go to SETTLED.
- **SETTLED**:
  - Score edge: go to SCORING.
  - Roll edge with `rolls_left`>0: capture `hold_mask`=`hold_sw`, decrement `rolls_left`, go to ROLLING.
  - Roll edge with `rolls_left`=0: ignored.
  - Simultaneous roll and score edges: score wins.
- **SCORING**:
  - `score_req`=1 until `score_ack` is sampled 1, then go to NEXT.
  - `score_ack` in any other state is ignored.
- **NEXT**:
  - `clear_dice`=1 for one cycle; `hold_mask`=0.
  - If `round_num`=`NUM_ROUNDS`: go to DONE.
  - Otherwise: `round_num`+1, `rolls_left`=`MAX_ROLLS`, go to IDLE.
- **DONE**:
  - `game_over`=1; all inputs ignored until `reset`.

## Timing
- All outputs are registered.
- Reset values: `roll_en`=0, `clear_dice`=0, `hold_mask`=0, `rolls_left`=`MAX_ROLLS`, `round_num`=1, `score_req`=0, `game_over`=0, state=CLEAR.
- `clear_dice` is high in the first cycle after `reset` deasserts.
- Button rising edge sampled at edge N: state changes at N+1, and the first `roll_en` is high in cycle N+1.
- Pulse k (0-based) is high in cycle N+1+k·`ANIM_PERIOD`. SETTLED is entered in the cycle after the last pulse.
- `rolls_left` updates in the same cycle as the first `roll_en` of that roll.
- `score_req` rises the cycle after the score edge. If `score_ack` is sampled at edge M, `score_req`=0 and `clear_dice`=1 at M+1.
- `reset` mid-roll or mid-handshake aborts immediately: no further `roll_en`, `score_req` drops, state returns to CLEAR.

## Configuration
- `AUTO_SCORE_EN` defined: when ROLLING finishes with `rolls_left`=0, go directly to SCORING instead of SETTLED, so `score_req` rises the cycle after the last `roll_en`.
- `AUTO_SCORE_EN` undefined: the turn waits in SETTLED for a score edge.

## Test plan
1. Release reset with `roll_btn` held high:
   - one `clear_dice` cycle, no roll.
   - release then press `roll_btn` → 8 `roll_en` pulses 16 cycles apart, `hold_mask`=0, `rolls_left`=2.
2. `hold_sw`=5'b10101 before the second roll, toggled to 0 mid-roll:
   - `hold_mask`=5'b10101 for all 8 pulses; `rolls_left`=1.
3. Third roll then a fourth roll press:
   - fourth press produces no `roll_en`; `rolls_left` stays 0.
   - `roll_btn` and `score_btn` rising in the same cycle at an earlier SETTLED → SCORING.
4. SCORING with `score_ack` delayed 5 cycles:
   - `score_req` high exactly 5+1 cycles, then `clear_dice` one cycle, `round_num` 1→2, `rolls_left`=3.
5. `NUM_ROUNDS`=2, play 2 turns:
   - `game_over`=1 after the second ack; further presses are ignored.
   - asserting `reset` mid-ROLLING kills `roll_en` the next cycle.
6. With `AUTO_SCORE_EN`, 3 rolls:
   - `score_req`=1 the cycle after the 24th `roll_en`, without `score_btn`.

Source files
------------

// File: rtl/yacht_turn_sequencer.sv
// Turn-level controller for one Yacht player: roll animation bursts, hold masking,
// roll budget, scoring handshake and round counting. Optional macro: AUTO_SCORE_EN.
module yacht_turn_sequencer #(
  parameter int MAX_ROLLS   = 3,
  parameter int ANIM_STEPS  = 8,
  parameter int ANIM_PERIOD = 16,
  parameter int NUM_ROUNDS  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_btn,
  input  logic       score_btn,
  input  logic [4:0] hold_sw,
  input  logic       score_ack,
  output logic       roll_en,
  output logic       clear_dice,
  output logic [4:0] hold_mask,
  output logic [1:0] rolls_left,
  output logic [3:0] round_num,
  output logic       score_req,
  output logic       game_over
);

  localparam logic [1:0]  ROLLS_INIT = 2'(MAX_ROLLS);
  localparam logic [7:0]  STEPS_LAST = 8'(ANIM_STEPS);
  localparam logic [15:0] PERIOD_END = 16'(ANIM_PERIOD - 1);
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    CLEAR, IDLE, ROLLING, SETTLED, SCORING, NEXT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        roll_prev, score_prev;
  logic [7:0]  step_cnt, step_nxt;
  logic [15:0] period_cnt, period_nxt;
  logic        roll_en_nxt, clear_dice_nxt, score_req_nxt, game_over_nxt;
  logic [4:0]  hold_mask_nxt;
  logic [1:0]  rolls_left_nxt;
  logic [3:0]  round_nxt;
  logic        roll_edge, score_edge;

  // Previous-value registers reset high so a button held through reset is not an edge
  assign roll_edge  = roll_btn & ~roll_prev;
  assign score_edge = score_btn & ~score_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      roll_prev  <= 1'b1;
      score_prev <= 1'b1;
      step_cnt   <= '0;
      period_cnt <= '0;
      roll_en    <= 1'b0;
      clear_dice <= 1'b0;
      hold_mask  <= '0;
      rolls_left <= ROLLS_INIT;
      round_num  <= 4'd1;
      score_req  <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      roll_prev  <= roll_btn;
      score_prev <= score_btn;
      step_cnt   <= step_nxt;
      period_cnt <= period_nxt;
      roll_en    <= roll_en_nxt;
      clear_dice <= clear_dice_nxt;
      hold_mask  <= hold_mask_nxt;
      rolls_left <= rolls_left_nxt;
      round_num  <= round_nxt;
      score_req  <= score_req_nxt;
      game_over  <= game_over_nxt;
    end
  end

  // Every output is computed one cycle ahead here and registered above
  always_comb begin
    state_nxt      = state;
    step_nxt       = step_cnt;
    period_nxt     = period_cnt;
    roll_en_nxt    = 1'b0;
    clear_dice_nxt = 1'b0;
    hold_mask_nxt  = hold_mask;
    rolls_left_nxt = rolls_left;
    round_nxt      = round_num;
    score_req_nxt  = score_req;
    game_over_nxt  = game_over;

    case (state)
      CLEAR: begin
        clear_dice_nxt = 1'b1;
        rolls_left_nxt = ROLLS_INIT;
        state_nxt      = IDLE;
      end
      IDLE: begin
        if (roll_edge) begin
          hold_mask_nxt  = '0;
          rolls_left_nxt = rolls_left - 2'd1;
          roll_en_nxt    = 1'b1;
          step_nxt       = 8'd1;
          period_nxt     = '0;
          state_nxt      = ROLLING;
        end
      end
      ROLLING: begin
        // step_cnt counts pulses already issued; the first one left with the button edge
        if (step_cnt == STEPS_LAST) begin
`ifdef AUTO_SCORE_EN
          if (rolls_left == 2'd0) begin
            score_req_nxt = 1'b1;
            state_nxt     = SCORING;
          end else begin
            state_nxt = SETTLED;
          end
`else
          state_nxt = SETTLED;
`endif
        end else if (period_cnt == PERIOD_END) begin
          roll_en_nxt = 1'b1;
          step_nxt    = step_cnt + 8'd1;
          period_nxt  = '0;
        end else begin
          period_nxt = period_cnt + 16'd1;
        end
      end
      SETTLED: begin
        if (score_edge) begin
          score_req_nxt = 1'b1;
          state_nxt     = SCORING;
        end else if (roll_edge && rolls_left != 2'd0) begin
          hold_mask_nxt  = hold_sw;
          rolls_left_nxt = rolls_left - 2'd1;
          roll_en_nxt    = 1'b1;
          step_nxt       = 8'd1;
          period_nxt     = '0;
          state_nxt      = ROLLING;
        end
      end
      SCORING: begin
        if (score_ack) begin
          score_req_nxt  = 1'b0;
          clear_dice_nxt = 1'b1;
          hold_mask_nxt  = '0;
          state_nxt      = NEXT;
        end
      end
      NEXT: begin
        if (round_num == LAST_ROUND) begin
          game_over_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          round_nxt      = round_num + 4'd1;
          rolls_left_nxt = ROLLS_INIT;
          state_nxt      = IDLE;
        end
      end
      DONE: begin
        game_over_nxt = 1'b1;
      end
      default: state_nxt = CLEAR;
    endcase
  end

endmodule
